note_remap_table: RTL and testbench



---
 rtl/note_remap_table_pkg.sv | 21 ++
 rtl/note_remap_table_key_debounce.sv | 37 +++
 rtl/note_remap_table.sv | 154 +++++++++++++++
 tb/tb_note_remap_table.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/note_remap_table_pkg.sv
// Shared constants for the note remap table: FSM encoding, note codes and the
// one-hot default mapping used at reset and on restore.
package note_remap_table_pkg;

   localparam int MAX_NOTE_W = 32;

   localparam logic [MAX_NOTE_W-1:0] NOTE_NONE = '0;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE,
      COMMIT,
      DONE
   } state_t;

   function automatic logic [MAX_NOTE_W-1:0] default_note(input int slot);
      return MAX_NOTE_W'(1) << slot;
   endfunction

endpackage

// File: rtl/note_remap_table_key_debounce.sv
// Key debouncer: flags a key code as stable once it has been sampled unchanged
// for HOLD_CYCLES consecutive clocks.
module key_debounce #(
   parameter int NOTE_W      = 7,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NOTE_W-1:0] note_in,
   output logic              stable_valid,
   output logic [NOTE_W-1:0] stable_value
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [NOTE_W-1:0] sample;
   logic [CNT_W-1:0]  count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample <= '0;
         count  <= '0;
      end else begin
         sample <= note_in;
         if (note_in != sample)
            count <= '0;
         else if (count != CNT_W'(HOLD_CYCLES))
            count <= count + CNT_W'(1);
      end
   end

   assign stable_valid = (count == CNT_W'(HOLD_CYCLES));
   assign stable_value = sample;

endmodule

// File: rtl/note_remap_table.sv
// Key remap table: captures one debounced press per slot into a shadow table and
// commits a complete sequence to the active table read by the playback path.
module note_remap_table
   import note_remap_table_pkg::*;
#(
   parameter  int NUM_SLOTS   = 7,
   parameter  int NOTE_W      = 7,
   parameter  int HOLD_CYCLES = 4,
   localparam int IDX_W       = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adjust_en,
   input  logic              cancel,
   input  logic              restore_default,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [IDX_W-1:0]  lookup_idx,
   output logic [NOTE_W-1:0] lookup_note,
   output logic [IDX_W-1:0]  slot_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [NOTE_W-1:0] NONE = NOTE_NONE[NOTE_W-1:0];

   logic [MAX_NOTE_W-1:0] default_wide  [NUM_SLOTS];
   logic [NOTE_W-1:0]     default_table [NUM_SLOTS];
   logic [NOTE_W-1:0]     active        [NUM_SLOTS];
   logic [NOTE_W-1:0]     shadow        [NUM_SLOTS];
   logic [NOTE_W-1:0]     cap_note;

   state_t state, state_next;

   logic              stable_valid;
   logic [NOTE_W-1:0] stable_value;

   logic load_shadow, capture, write_slot, slot_clear, slot_inc, commit, restore;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_default
      assign default_wide[i]  = default_note(i);
      assign default_table[i] = default_wide[i][NOTE_W-1:0];
   end

   key_debounce #(
      .NOTE_W      (NOTE_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .note_in      (note_in),
      .stable_valid (stable_valid),
      .stable_value (stable_value)
   );

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next  = state;
      load_shadow = 1'b0;
      capture     = 1'b0;
      write_slot  = 1'b0;
      slot_clear  = 1'b0;
      slot_inc    = 1'b0;
      commit      = 1'b0;
      restore     = 1'b0;
      case (state)
         IDLE: begin
            restore = restore_default;
            if (adjust_en && !cancel) begin
               state_next  = WAIT_PRESS;
               load_shadow = 1'b1;
               slot_clear  = 1'b1;
            end
         end
         WAIT_PRESS: begin
            if (!adjust_en || cancel) begin
               state_next = IDLE;
               slot_clear = 1'b1;
            end else if (stable_valid && stable_value != NONE) begin
               capture    = 1'b1;
               state_next = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!adjust_en || cancel) begin
               state_next = IDLE;
               slot_clear = 1'b1;
            end else if (stable_valid && stable_value == NONE) begin
               write_slot = 1'b1;
               if (slot_idx == IDX_W'(NUM_SLOTS - 1)) begin
                  state_next = COMMIT;
               end else begin
                  slot_inc   = 1'b1;
                  state_next = WAIT_PRESS;
               end
            end
         end
         COMMIT: begin
            commit     = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            restore = restore_default;
            if (!adjust_en)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: both tables are reset because the active table must hold valid
   // defaults the moment reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         slot_idx    <= '0;
         cap_note    <= '0;
         lookup_note <= default_table[0];
         for (int i = 0; i < NUM_SLOTS; i++) begin
            active[i] <= default_table[i];
            shadow[i] <= default_table[i];
         end
      end else begin
         state <= state_next;

         if (slot_clear)
            slot_idx <= '0;
         else if (slot_inc)
            slot_idx <= slot_idx + IDX_W'(1);

         if (capture)
            cap_note <= stable_value;

         if (load_shadow)
            shadow <= active;
         else if (write_slot)
            shadow[slot_idx] <= cap_note;

         // Commit and restore are mutually exclusive by state, commit first.
         if (commit)
            active <= shadow;
         else if (restore)
            active <= default_table;

         if (int'(lookup_idx) < NUM_SLOTS)
            lookup_note <= active[lookup_idx];
         else
            lookup_note <= '0;
      end
   end

   assign busy = (state == WAIT_PRESS) || (state == WAIT_RELEASE) || (state == COMMIT);
   assign done = (state == COMMIT);

endmodule

// File: tb/tb_note_remap_table.sv
// Directed bench for note_remap_table: capture sessions, debounce glitches,
// aborts, cancel re-arm, restore_default gating and commit-cycle lookup.
module tb_note_remap_table;

   localparam int NUM_SLOTS   = 7;
   localparam int NOTE_W      = 7;
   localparam int HOLD_CYCLES = 4;
   localparam int IDX_W       = $clog2(NUM_SLOTS);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              adjust_en;
   logic              cancel;
   logic              restore_default;
   logic [NOTE_W-1:0] note_in;
   logic [IDX_W-1:0]  lookup_idx;
   logic [NOTE_W-1:0] lookup_note;
   logic [IDX_W-1:0]  slot_idx;
   logic              busy;
   logic              done;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int done_cnt  = 0;
   logic [NOTE_W-1:0] commit_lookup = '0;

   always #5 clk = ~clk;

   note_remap_table #(
      .NUM_SLOTS   (NUM_SLOTS),
      .NOTE_W      (NOTE_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .adjust_en       (adjust_en),
      .cancel          (cancel),
      .restore_default (restore_default),
      .note_in         (note_in),
      .lookup_idx      (lookup_idx),
      .lookup_note     (lookup_note),
      .slot_idx        (slot_idx),
      .busy            (busy),
      .done            (done)
   );

   // Count done pulses and remember what the lookup port showed during commit.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt      <= done_cnt + 1;
         commit_lookup <= lookup_note;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [NOTE_W-1:0] code, input int hold, input int gap);
      note_in = code;
      tick(hold);
      note_in = '0;
      tick(gap);
   endtask

   task automatic read_slot(input int idx, input logic [NOTE_W-1:0] exp, input string tag);
      lookup_idx = IDX_W'(idx);
      tick();
      check(tag, 32'(lookup_note), 32'(exp));
   endtask

   logic [NOTE_W-1:0] tbl3 [NUM_SLOTS];

   initial begin
      rst_n           = 1'b0;
      adjust_en       = 1'b0;
      cancel          = 1'b0;
      restore_default = 1'b0;
      note_in         = '0;
      lookup_idx      = '0;
      tick(3);
      check("rst_lookup", 32'(lookup_note), 32'h01);
      check("rst_slot",   32'(slot_idx),    32'h0);
      rst_n = 1'b1;
      tick(2);

      // 1: one-hot defaults, busy/done idle, out-of-range index
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_done", 32'(done), 32'h0);
      for (int i = 0; i < NUM_SLOTS; i++)
         read_slot(i, NOTE_W'(1 << i), $sformatf("t1_default_%0d", i));
      read_slot(7, 7'h00, "t1_oob_idx");

      // 2: full reversed session; lookup idx 0 held to catch the commit cycle
      lookup_idx = '0;
      adjust_en  = 1'b1;
      tick();
      check("t2_busy_start", 32'(busy), 32'h1);
      for (int k = 0; k < NUM_SLOTS; k++) begin
         check($sformatf("t2_slot_%0d", k), 32'(slot_idx), 32'(k));
         press(NOTE_W'(7'h40 >> k), 10, 10);
      end
      check("t2_done_cnt",      32'(done_cnt),      32'd1);
      check("t2_commit_lookup", 32'(commit_lookup), 32'h01);
      check("t2_busy_done",     32'(busy),          32'h0);
      read_slot(0, 7'h40, "t2_idx0");
      read_slot(3, 7'h08, "t2_idx3");
      read_slot(6, 7'h01, "t2_idx6");
      adjust_en = 1'b0;
      tick(2);

      // 3 + 6: glitch ignored on slot 0, first latched code wins on slot 1
      tbl3 = '{7'h08, 7'h02, 7'h7f, 7'h11, 7'h22, 7'h33, 7'h44};
      adjust_en = 1'b1;
      tick();
      note_in = 7'h04;
      tick(2);
      press(7'h08, 10, 10);
      check("t3_slot_after_glitch", 32'(slot_idx), 32'h1);
      note_in = 7'h02;
      tick(10);
      press(7'h10, 10, 10);
      check("t6_slot_after_switch", 32'(slot_idx), 32'h2);
      for (int k = 2; k < NUM_SLOTS; k++)
         press(tbl3[k], 10, 10);
      check("t3_done_cnt", 32'(done_cnt), 32'd2);
      for (int i = 0; i < NUM_SLOTS; i++)
         read_slot(i, tbl3[i], $sformatf("t3_tbl_%0d", i));
      adjust_en = 1'b0;
      tick(2);

      // 4: abort after three slots leaves active untouched
      adjust_en = 1'b1;
      tick();
      for (int k = 0; k < 3; k++)
         press(7'h01, 10, 10);
      check("t4_slot3", 32'(slot_idx), 32'h3);
      adjust_en = 1'b0;
      tick();
      check("t4_abort_busy", 32'(busy),     32'h0);
      check("t4_abort_slot", 32'(slot_idx), 32'h0);
      tick(2);
      check("t4_no_done", 32'(done_cnt), 32'd2);
      read_slot(0, 7'h08, "t4_keep0");
      read_slot(2, 7'h7f, "t4_keep2");
      adjust_en = 1'b1;
      tick();
      check("t4_rearm_slot", 32'(slot_idx), 32'h0);
      check("t4_rearm_busy", 32'(busy),     32'h1);

      // 6: cancel mid-session drops to IDLE then re-arms at slot 0
      press(7'h05, 10, 10);
      check("t6_slot1", 32'(slot_idx), 32'h1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("t6_cancel_busy", 32'(busy),     32'h0);
      check("t6_cancel_slot", 32'(slot_idx), 32'h0);
      tick();
      check("t6_restart_busy", 32'(busy),     32'h1);
      check("t6_restart_slot", 32'(slot_idx), 32'h0);
      read_slot(0, 7'h08, "t6_keep0");

      // 5: restore ignored mid-session, honoured in DONE
      restore_default = 1'b1;
      tick();
      restore_default = 1'b0;
      read_slot(0, 7'h08, "t5_midsession_ignored");
      read_slot(4, 7'h22, "t5_midsession_keep4");
      for (int k = 0; k < NUM_SLOTS; k++)
         press(7'h03, 10, 10);
      check("t5_done_cnt", 32'(done_cnt), 32'd3);
      read_slot(4, 7'h03, "t5_session_idx4");
      restore_default = 1'b1;
      tick();
      restore_default = 1'b0;
      read_slot(4, 7'h10, "t5_restored_idx4");
      read_slot(0, 7'h01, "t5_restored_idx0");
      read_slot(6, 7'h40, "t5_restored_idx6");
      adjust_en = 1'b0;
      tick(2);
      check("t5_final_done_cnt", 32'(done_cnt), 32'd3);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
